// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction word per IR_w over a
// req/ack memory handshake with a bounded wait, latches it into IR and slices its fields.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IR_w,
    input  logic              PC_w,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_next_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [5:0]        OPCODE,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Fetch FSM, PC register and IR latch; busy tracks "state != IDLE" as a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            ir_valid  <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
            cnt       <= '0;
        end else begin
            if (PC_w) begin
                pc <= pc_load ? pc_next_in : pc + ADDR_W'(PC_STEP);
            end

            case (state)
                S_IDLE: begin
                    if (IR_w) begin
                        mem_addr  <= pc;
                        mem_rd    <= 1'b1;
                        ir_valid  <= 1'b0;
                        fetch_err <= 1'b0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        ir_valid <= 1'b1;
                        mem_rd   <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            mem_rd    <= 1'b0;
                            fetch_err <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mem_rd <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Field slices of the registered IR.
    assign OPCODE = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm16  = ir[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        reset, IR_w, PC_w, pc_load, mem_ack;
    logic [31:0] pc_next_in, mem_rdata;
    logic [31:0] mem_addr, pc, ir;
    logic        mem_rd, ir_valid, busy, fetch_err;
    logic [5:0]  OPCODE, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .IR_w(IR_w), .PC_w(PC_w), .pc_load(pc_load),
        .pc_next_in(pc_next_in), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc), .ir(ir), .OPCODE(OPCODE),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
        .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err)
    );

    // Model: a fetch is either absent, outstanding (with its age in cycles), or just timed out.
    logic [31:0] m_pc, m_ir, m_addr;
    logic        m_valid, m_err;
    bit          m_outstanding, m_err_cycle;
    int          m_age;

    task automatic model_step();
        if (!reset) begin
            m_pc = 0; m_ir = 0; m_addr = 0; m_valid = 0; m_err = 0;
            m_outstanding = 0; m_err_cycle = 0; m_age = 0;
        end else begin
            logic [31:0] old_pc;
            old_pc = m_pc;
            if (PC_w) m_pc = pc_load ? pc_next_in : m_pc + 32'd4;
            if (m_err_cycle) begin
                m_err_cycle = 0;
            end else if (m_outstanding) begin
                if (mem_ack) begin
                    m_ir = mem_rdata; m_valid = 1; m_outstanding = 0;
                end else begin
                    m_age++;
                    if (m_age >= TO) begin
                        m_outstanding = 0; m_err = 1; m_err_cycle = 1;
                    end
                end
            end else if (IR_w) begin
                m_addr = old_pc; m_outstanding = 1; m_age = 0; m_valid = 0; m_err = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("mem_rd", 32'(mem_rd), 32'(m_outstanding));
        if (m_outstanding) chk("mem_addr", mem_addr, m_addr);
        chk("ir_valid", 32'(ir_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_outstanding || m_err_cycle));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        chk("OPCODE", 32'(OPCODE), m_ir >> 26);
        chk("rs", 32'(rs), (m_ir >> 21) & 32'h1f);
        chk("rt", 32'(rt), (m_ir >> 16) & 32'h1f);
        chk("rd", 32'(rd), (m_ir >> 11) & 32'h1f);
        chk("shamt", 32'(shamt), (m_ir >> 6) & 32'h1f);
        chk("funct", 32'(funct), m_ir & 32'h3f);
        chk("imm16", 32'(imm16), m_ir & 32'hffff);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset = 0; IR_w = 0; PC_w = 0; pc_load = 0; pc_next_in = 0;
        mem_ack = 0; mem_rdata = 0;

        // 1) reset held two cycles
        tick(); tick();
        reset = 1;
        tick();
        chk("t1_pc", pc, 32'h0);
        chk("t1_ir", ir, 32'h0);
        chk("t1_opcode", 32'(OPCODE), 32'h0);
        chk("t1_mem_rd", 32'(mem_rd), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);

        // 2) fetch acked three cycles after the request
        IR_w = 1; tick(); IR_w = 0;
        chk("t2_mem_rd", 32'(mem_rd), 32'h1);
        chk("t2_mem_addr", mem_addr, 32'h0);
        tick(); tick();
        mem_ack = 1; mem_rdata = 32'h2008_0005; tick(); mem_ack = 0;
        chk("t2_opcode", 32'(OPCODE), 32'h08);
        chk("t2_rs", 32'(rs), 32'h0);
        chk("t2_rt", 32'(rt), 32'h8);
        chk("t2_imm16", 32'(imm16), 32'h5);
        chk("t2_ir_valid", 32'(ir_valid), 32'h1);
        chk("t2_busy", 32'(busy), 32'h0);

        // 3) fetch and PC step at the same edge, then a PC load mid-fetch
        IR_w = 1; PC_w = 1; pc_load = 0; tick(); IR_w = 0;
        chk("t3_mem_addr", mem_addr, 32'h0);
        chk("t3_pc_step", pc, 32'h4);
        pc_load = 1; pc_next_in = 32'h40; tick(); PC_w = 0; pc_load = 0;
        chk("t3_pc_load", pc, 32'h40);
        mem_ack = 1; mem_rdata = 32'h1234_5678; tick(); mem_ack = 0;

        // 4) timeout after 15 unanswered WAIT cycles
        IR_w = 1; tick(); IR_w = 0;
        chk("t4_addr", mem_addr, 32'h40);
        repeat (TO - 1) tick();
        chk("t4_rd_held", 32'(mem_rd), 32'h1);
        tick();
        chk("t4_rd_drop", 32'(mem_rd), 32'h0);
        chk("t4_err", 32'(fetch_err), 32'h1);
        chk("t4_busy_err", 32'(busy), 32'h1);
        chk("t4_ir_kept", ir, 32'h1234_5678);
        chk("t4_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("t4_idle", 32'(busy), 32'h0);
        IR_w = 1; tick(); IR_w = 0;
        chk("t4_err_clr", 32'(fetch_err), 32'h0);

        // 5) reset mid-fetch, then a late ack
        tick();
        reset = 0; tick(); reset = 1;
        mem_ack = 1; mem_rdata = 32'hcafe_f00d; tick(); mem_ack = 0;
        chk("t5_mem_rd", 32'(mem_rd), 32'h0);
        chk("t5_ir", ir, 32'h0);
        chk("t5_valid", 32'(ir_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);

        // 6) PC wrap and a spurious ack while idle
        PC_w = 1; pc_load = 1; pc_next_in = 32'hffff_fffc; tick();
        pc_load = 0; tick(); PC_w = 0;
        chk("t6_wrap", pc, 32'h0);
        mem_ack = 1; mem_rdata = 32'hdead_beef; tick(); mem_ack = 0;
        chk("t6_spurious", ir, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 249) != 0);
            IR_w       = ($urandom_range(0, 2) == 0);
            PC_w       = ($urandom_range(0, 3) == 0);
            pc_load    = $urandom_range(0, 1) == 1;
            pc_next_in = ($urandom_range(0, 7) == 0) ? 32'hffff_fffc : $urandom;
            mem_ack    = mem_rd ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 11) == 0);
            mem_rdata  = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
